// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared definitions for the FP operation sequencer.
//   Op-code constants, sequencer state enum, rounding-mode constants,
//   latency counter width and a helper that flags reserved rounding modes.
package fpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_MUL  = 6'd1;
    localparam logic [5:0] OP_DIV  = 6'd2;
    localparam logic [5:0] OP_SQRT = 6'd3;
    localparam logic [5:0] OP_CVT  = 6'd4;

    localparam logic [2:0] RM_DYN  = 3'b111;
    localparam logic [2:0] RM_ILL0 = 3'b101;
    localparam logic [2:0] RM_ILL1 = 3'b110;

    // Wide enough for any practical unit latency.
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic rm_illegal(input logic [2:0] rm);
        return (rm == RM_ILL0) || (rm == RM_ILL1);
    endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// fpu_lat_lut -- combinational op-code decoder.
//   op_i      : operation code
//   lat_o     : execution latency in cycles for a legal op
//   illegal_o : op code is not one of add/mul/div/sqrt/cvt
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 12,
    parameter int LAT_CVT  = 1
) (
    input  logic [5:0]       op_i,
    output logic [CNT_W-1:0] lat_o,
    output logic             illegal_o
);

    always_comb begin
        lat_o     = CNT_W'(1);
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  lat_o = CNT_W'(LAT_ADD);
            OP_MUL:  lat_o = CNT_W'(LAT_MUL);
            OP_DIV:  lat_o = CNT_W'(LAT_DIV);
            OP_SQRT: lat_o = CNT_W'(LAT_SQRT);
            OP_CVT:  lat_o = CNT_W'(LAT_CVT);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq -- sequences one FP operation at a time between the core and a
// fixed-latency downstream FPU.
//   clk, resetn          : clock; synchronous reset, active HIGH despite the name
//   req_valid/req_ready  : request handshake (op, rs1, rs2, rd, rm, fcsr)
//   flush                : abandon the operation in flight, no response
//   fpu_operation/rs1/rs2/fcsr, fpu_result : downstream FPU interface
//   rsp_valid/rsp_ready  : response handshake (rsp_result, rsp_rd, rsp_illegal)
// Build option: define FPU_SEQ_BACK2BACK_EN to accept a new request in the
// same cycle a response is handed off.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int FLEN     = 32,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 12,
    parameter int LAT_CVT  = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_op,
    input  logic [FLEN-1:0] req_rs1,
    input  logic [FLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic [2:0]      req_rm,
    input  logic [31:0]     fcsr,
    input  logic            flush,
    output logic [5:0]      fpu_operation,
    output logic [FLEN-1:0] fpu_rs1,
    output logic [FLEN-1:0] fpu_rs2,
    output logic [31:0]     fpu_fcsr,
    input  logic [FLEN-1:0] fpu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FLEN-1:0] rsp_result,
    output logic [4:0]      rsp_rd,
    output logic            rsp_illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d;
    logic [FLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]      fcsr_q, fcsr_d;
    logic [4:0]       rd_q, rd_d;
    logic [FLEN-1:0]  res_q, res_d;
    logic [4:0]       rsp_rd_q, rsp_rd_d;
    logic             ill_q, ill_d;

    logic [CNT_W-1:0] lat;
    logic             op_ill;
    logic [2:0]       rm_res;
    logic             req_ill;
    logic             accept;

    fpu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_CVT  (LAT_CVT)
    ) u_lut (
        .op_i      (req_op),
        .lat_o     (lat),
        .illegal_o (op_ill)
    );

    assign rm_res  = (req_rm == RM_DYN) ? fcsr[7:5] : req_rm;
    assign req_ill = op_ill || rm_illegal(rm_res);

    // Acceptance is blocked by flush and by reset in the same cycle.
`ifdef FPU_SEQ_BACK2BACK_EN
    assign req_ready = !resetn && !flush &&
                       ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
`else
    assign req_ready = !resetn && !flush && (state_q == ST_IDLE);
`endif
    assign accept = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        fcsr_d   = fcsr_q;
        rd_d     = rd_q;
        res_d    = res_q;
        rsp_rd_d = rsp_rd_q;
        ill_d    = ill_q;
        if (flush) begin
            // Flush beats counter expiry and the response handshake.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_RESP;
                        res_d    = fpu_result;
                        rsp_rd_d = rd_q;
                        ill_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: if (rsp_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // A new request overrides the RESP->IDLE return when back-to-back is enabled.
            if (accept) begin
                op_d   = req_op;
                rs1_d  = req_rs1;
                rs2_d  = req_rs2;
                rd_d   = req_rd;
                fcsr_d = {fcsr[31:8], rm_res, fcsr[4:0]};
                if (req_ill) begin
                    state_d  = ST_RESP;
                    cnt_d    = '0;
                    res_d    = '0;
                    rsp_rd_d = req_rd;
                    ill_d    = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                    cnt_d   = lat - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            fcsr_q   <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            rsp_rd_q <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            fcsr_q   <= fcsr_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            rsp_rd_q <= rsp_rd_d;
            ill_q    <= ill_d;
        end
    end

    // The FPU only sees an operation while it is executing.
    assign fpu_operation = (state_q == ST_EXEC) ? op_q : 6'd0;
    assign fpu_rs1       = rs1_q;
    assign fpu_rs2       = rs2_q;
    assign fpu_fcsr      = fcsr_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_result    = res_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_illegal   = ill_q;

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq -- directed scenarios plus randomized traffic for fpu_seq,
// checked cycle by cycle against a transaction-level model of the sequencer.
// The bench acts as the downstream FPU and only presents the correct result
// in the cycle the sequencer is due to capture it.
module tb_fpu_seq;

    localparam int FLEN = 32, LAT_ADD = 3, LAT_MUL = 3, LAT_DIV = 12, LAT_SQRT = 12, LAT_CVT = 1;
`ifdef FPU_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b1, req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_illegal;
    logic [5:0]  req_op = '0, fpu_operation;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, fcsr = '0, fpu_result = '0;
    logic [31:0] fpu_rs1, fpu_rs2, fpu_fcsr, rsp_result;
    logic [4:0]  req_rd = '0, rsp_rd;
    logic [2:0]  req_rm = '0;

    fpu_seq #(.FLEN(FLEN), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
              .LAT_SQRT(LAT_SQRT), .LAT_CVT(LAT_CVT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_rm(req_rm), .fcsr(fcsr), .flush(flush), .fpu_operation(fpu_operation),
        .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_fcsr(fpu_fcsr), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal)
    );

    int n_vec = 0, n_err = 0, cyc = 0;

    // Model: at most one transaction, described by when it was accepted.
    bit          has_txn = 1'b0, t_ill = 1'b0;
    int          t_acc = 0, t_lat = 0;
    logic [5:0]  t_op = '0;
    logic [31:0] t_res = '0, e_rs1 = '0, e_rs2 = '0, e_fcsr = '0;
    logic [4:0]  t_rd = '0;

    // Last observed outputs, for the directed scenario checks.
    logic        o_rdy, o_rv, o_ill;
    logic [5:0]  o_op;
    logic [31:0] o_res, o_rs1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'd0: return LAT_ADD;
            6'd1: return LAT_MUL;
            6'd2: return LAT_DIV;
            6'd3: return LAT_SQRT;
            default: return LAT_CVT;
        endcase
    endfunction

    // Stand-in FPU arithmetic: exact for 1.0 + 2.0, an operand hash otherwise.
    function automatic logic [31:0] golden(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [2:0] rm);
        if (op == 6'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return (a + {b[15:0], b[31:16]}) ^ {op[2:0], rm, 26'h0};
    endfunction

    task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [2:0] rm,
                        input logic [31:0] cs, input logic fl, input logic rdy, input logic rst);
        logic [2:0] rmr;
        bit ill, in_exec, in_resp, e_rdy;
        @(negedge clk);
        req_valid = v; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        req_rm = rm; fcsr = cs; flush = fl; rsp_ready = rdy; resetn = rst;
        in_exec = has_txn && (cyc <= t_acc + t_lat);
        in_resp = has_txn && !in_exec;
        fpu_result = (has_txn && !t_ill && cyc == t_acc + t_lat) ? t_res
                                                                 : (t_res ^ 32'hA5A50000 ^ 32'(cyc));
        e_rdy = !rst && !fl && (!has_txn || (B2B && in_resp && rdy));
        #1;
        o_rdy = req_ready; o_rv = rsp_valid; o_ill = rsp_illegal;
        o_op = fpu_operation; o_res = rsp_result; o_rs1 = fpu_rs1;
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, in_resp);
        chk("fpu_operation", fpu_operation, in_exec ? t_op : 6'd0);
        chk("fpu_rs1", fpu_rs1, e_rs1);
        chk("fpu_rs2", fpu_rs2, e_rs2);
        chk("fpu_fcsr", fpu_fcsr, e_fcsr);
        if (in_resp) begin
            chk("rsp_result", rsp_result, t_res);
            chk("rsp_rd", rsp_rd, t_rd);
            chk("rsp_illegal", rsp_illegal, t_ill);
        end
        @(posedge clk);
        if (rst) begin
            has_txn = 1'b0; e_rs1 = '0; e_rs2 = '0; e_fcsr = '0;
        end else if (fl) begin
            has_txn = 1'b0;
        end else begin
            if (in_resp && rdy) has_txn = 1'b0;
            if (v && e_rdy) begin
                rmr = (rm == 3'b111) ? cs[7:5] : rm;
                ill = (op > 6'd4) || (rmr == 3'b101) || (rmr == 3'b110);
                has_txn = 1'b1; t_acc = cyc; t_ill = ill; t_op = op; t_rd = rd;
                t_lat = ill ? 0 : lat_of(op);
                t_res = ill ? 32'h0 : golden(op, a, b, rmr);
                e_rs1 = a; e_rs2 = b; e_fcsr = {cs[31:8], rmr, cs[4:0]};
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Reset values
        idle(1'b1);
        chk("rst_rsp_valid", o_rv, 1'b0);
        chk("rst_fpu_op", o_op, 6'd0);
        chk("rst_fpu_rs1", o_rs1, 32'h0);
        chk("rst_rsp_result", o_res, 32'h0);
        chk("rst_rsp_illegal", o_ill, 1'b0);

        // add 1.0 + 2.0, dynamic rounding
        step(1'b1, 6'd0, 32'h3F800000, 32'h40000000, 5'd5, 3'b111, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            if (k == 3) chk("add_early", o_rv, 1'b0);
            if (k == 4) begin
                chk("add_valid", o_rv, 1'b1);
                chk("add_result", o_res, 32'h40400000);
                chk("add_illegal", o_ill, 1'b0);
            end
        end

        // div with a stalled response
        step(1'b1, 6'd2, 32'h12345678, 32'h0BADF00D, 5'd9, 3'd1, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            idle(k == 18);
            if (k == 12) chk("div_early", o_rv, 1'b0);
            if (k >= 13 && k <= 18) begin
                chk("div_valid", o_rv, 1'b1);
                chk("div_result", o_res, golden(6'd2, 32'h12345678, 32'h0BADF00D, 3'd1));
            end
            if (k == 19) begin
                chk("div_done_valid", o_rv, 1'b0);
                chk("div_done_ready", o_rdy, 1'b1);
            end
        end

        // illegal op, then illegal rounding mode
        step(1'b1, 6'd7, 32'h1, 32'h2, 5'd3, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("illop_valid", o_rv, 1'b1);
        chk("illop_flag", o_ill, 1'b1);
        chk("illop_result", o_res, 32'h0);
        chk("illop_fpu_op", o_op, 6'd0);
        step(1'b1, 6'd1, 32'h1, 32'h2, 5'd4, 3'b101, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("illrm_valid", o_rv, 1'b1);
        chk("illrm_flag", o_ill, 1'b1);
        idle(1'b1);

        // flush in the middle of a sqrt
        step(1'b1, 6'd3, 32'h40800000, 32'h0, 5'd7, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) idle(1'b1);
        step(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_sqrt_op", o_op, 6'd3);
        idle(1'b1);
        chk("flush_ready", o_rdy, 1'b1);
        chk("flush_novalid", o_rv, 1'b0);

        // back-to-back cvt
        step(1'b1, 6'd4, 32'h00000011, 32'h0, 5'd1, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b1, 6'd4, 32'h00000022, 32'h0, 5'd2, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("b2b_valid", o_rv, 1'b1);
        chk("b2b_ready", o_rdy, B2B);
        if (!B2B) begin
            step(1'b1, 6'd4, 32'h00000022, 32'h0, 5'd2, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("gap_ready", o_rdy, 1'b1);
        end
        for (int k = 0; k < 4; k++) idle(1'b1);

        // reset while a mul executes
        step(1'b1, 6'd1, 32'hCAFE0001, 32'h00C0FFEE, 5'd6, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("mulrst_valid", o_rv, 1'b0);
        chk("mulrst_fpu_op", o_op, 6'd0);
        chk("mulrst_fpu_rs1", o_rs1, 32'h0);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] rop;
            rop = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
            step(1'($urandom_range(0, 1)), rop, $urandom, $urandom, 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
